// File: rtl/data_memory_dma_pkg.sv
// Shared types and defaults for the data-memory DMA engine.
// Holds the FSM state encoding, transfer-mode encodings and default bus widths.
package data_memory_dma_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_LEN_WIDTH  = 8;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_WRITE   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/data_memory_dma.sv
// Block copy / block fill engine driving the DataMemory port beside the CPU.
// Strobes come from registers and are masked whenever the CPU holds the memory.
import data_memory_dma_pkg::*;

module data_memory_dma #(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] srcAddr,
   input  logic [ADDR_WIDTH-1:0] dstAddr,
   input  logic [LEN_WIDTH-1:0]  length,
   input  logic [DATA_WIDTH-1:0] fillValue,
   input  logic                  cpuHold,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  MemRead,
   output logic                  MemWrite,
   input  logic [DATA_WIDTH-1:0] dataOut
);

   state_t                r_state;
   state_t                w_next_state;

   logic                  r_mode;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [DATA_WIDTH-1:0] r_fill;
   logic [LEN_WIDTH-1:0]  r_index;
   logic [DATA_WIDTH-1:0] r_buffer;
   logic [ADDR_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0] r_write_data;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_start;
   logic                  w_mode;
   logic [ADDR_WIDTH-1:0] w_src;
   logic [ADDR_WIDTH-1:0] w_dst;
   logic [LEN_WIDTH-1:0]  w_len;
   logic [DATA_WIDTH-1:0] w_fill;
   logic [LEN_WIDTH-1:0]  w_index_inc;
   logic [LEN_WIDTH-1:0]  w_index_next;
   logic [DATA_WIDTH-1:0] w_buffer_next;
   logic                  w_last;
   logic [ADDR_WIDTH-1:0] w_address_next;
   logic [DATA_WIDTH-1:0] w_write_data_next;
   logic                  w_mem_read_next;
   logic                  w_mem_write_next;

   // start only counts in IDLE; operands are taken straight from the inputs on that edge
   always_comb begin
      w_start       = (r_state == ST_IDLE) && start;
      w_mode        = w_start ? mode      : r_mode;
      w_src         = w_start ? srcAddr   : r_src;
      w_dst         = w_start ? dstAddr   : r_dst;
      w_len         = w_start ? length    : r_len;
      w_fill        = w_start ? fillValue : r_fill;
      w_index_inc   = r_index + LEN_WIDTH'(1);
      w_last        = (w_index_inc == r_len);
      w_buffer_next = (r_state == ST_CAPTURE) ? dataOut : r_buffer;
      if (w_start) begin
         w_index_next = {LEN_WIDTH{1'b0}};
      end else if ((r_state == ST_WRITE) && !cpuHold) begin
         w_index_next = w_index_inc;
      end else begin
         w_index_next = r_index;
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!start) begin
               w_next_state = ST_IDLE;
            end else if (length == {LEN_WIDTH{1'b0}}) begin
               w_next_state = ST_DONE;
            end else if (mode == MODE_FILL) begin
               w_next_state = ST_WRITE;
            end else begin
               w_next_state = ST_READ;
            end
         end
         ST_READ:    w_next_state = cpuHold ? ST_READ : ST_CAPTURE;
         ST_CAPTURE: w_next_state = ST_WRITE;
         ST_WRITE: begin
            if (cpuHold) begin
               w_next_state = ST_WRITE;
            end else if (w_last) begin
               w_next_state = ST_DONE;
            end else if (r_mode == MODE_FILL) begin
               w_next_state = ST_WRITE;
            end else begin
               w_next_state = ST_READ;
            end
         end
         ST_DONE:    w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Output logic: bus values for the cycle spent in the next state
   always_comb begin
      w_address_next    = r_address;
      w_write_data_next = r_write_data;
      w_mem_read_next   = 1'b0;
      w_mem_write_next  = 1'b0;
      case (w_next_state)
         ST_READ: begin
            w_address_next  = w_src + ADDR_WIDTH'(w_index_next);
            w_mem_read_next = 1'b1;
         end
         ST_WRITE: begin
            w_address_next    = w_dst + ADDR_WIDTH'(w_index_next);
            w_write_data_next = (w_mode == MODE_FILL) ? w_fill : w_buffer_next;
            w_mem_write_next  = 1'b1;
         end
         default: begin
            w_address_next = r_address;
         end
      endcase
   end

   // Operand latches, index counter, capture buffer and registered bus outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mode       <= MODE_COPY;
         r_src        <= {ADDR_WIDTH{1'b0}};
         r_dst        <= {ADDR_WIDTH{1'b0}};
         r_len        <= {LEN_WIDTH{1'b0}};
         r_fill       <= {DATA_WIDTH{1'b0}};
         r_index      <= {LEN_WIDTH{1'b0}};
         r_buffer     <= {DATA_WIDTH{1'b0}};
         r_address    <= {ADDR_WIDTH{1'b0}};
         r_write_data <= {DATA_WIDTH{1'b0}};
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_mode       <= w_mode;
         r_src        <= w_src;
         r_dst        <= w_dst;
         r_len        <= w_len;
         r_fill       <= w_fill;
         r_index      <= w_index_next;
         r_buffer     <= w_buffer_next;
         r_address    <= w_address_next;
         r_write_data <= w_write_data_next;
         r_mem_read   <= w_mem_read_next;
         r_mem_write  <= w_mem_write_next;
         r_busy       <= (w_next_state != ST_IDLE);
         r_done       <= (w_next_state == ST_DONE);
      end
   end

   // A held READ/WRITE keeps its strobe register set; the CPU mask keeps the bus quiet
   assign MemRead   = r_mem_read  & ~cpuHold;
   assign MemWrite  = r_mem_write & ~cpuHold;
   assign address   = r_address;
   assign writeData = r_write_data;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_data_memory_dma.sv
// Directed self-checking bench for data_memory_dma with a synchronous DataMemory model.
module tb_data_memory_dma;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] srcAddr;
   logic [7:0] dstAddr;
   logic [7:0] length;
   logic [7:0] fillValue;
   logic       cpuHold;
   logic       busy;
   logic       done;
   logic [7:0] address;
   logic [7:0] writeData;
   logic       MemRead;
   logic       MemWrite;
   logic [7:0] dataOut;

   logic [7:0] mem [256];
   logic       pre_we;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;

   int n_assert = 0;
   int n_fail   = 0;
   int n_viol   = 0;
   int n_done   = 0;

   data_memory_dma dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode),
      .srcAddr(srcAddr), .dstAddr(dstAddr), .length(length),
      .fillValue(fillValue), .cpuHold(cpuHold), .busy(busy), .done(done),
      .address(address), .writeData(writeData), .MemRead(MemRead),
      .MemWrite(MemWrite), .dataOut(dataOut)
   );

   always #5 clock = ~clock;

   // DataMemory: synchronous read (dataOut valid the cycle after MemRead), synchronous write
   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (MemWrite) mem[address] <= writeData;
      if (MemRead) dataOut <= mem[address];
   end

   // Bus-rule monitor and done pulse counter
   always @(negedge clock) begin
      if (!reset) begin
         if (MemRead && MemWrite) n_viol++;
         if (cpuHold && (MemRead || MemWrite)) n_viol++;
         if (done) n_done++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      step();
      pre_we = 1'b0;
   endtask

   task automatic kick(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input logic [7:0] f);
      start = 1'b1; mode = m; srcAddr = s; dstAddr = d; length = l; fillValue = f;
      step();
      start = 1'b0; mode = 1'b0; srcAddr = 8'h00; dstAddr = 8'h00; length = 8'h00; fillValue = 8'h00;
   endtask

   initial begin
      logic [7:0] a;
      int done_before;
      reset = 1'b1; start = 1'b0; mode = 1'b0; srcAddr = 8'h00; dstAddr = 8'h00;
      length = 8'h00; fillValue = 8'h00; cpuHold = 1'b0; pre_we = 1'b0;
      pre_addr = 8'h00; pre_data = 8'h00;
      step(); step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      chk("rst_address", {24'd0, address}, 32'd0);
      chk("rst_wdata", {24'd0, writeData}, 32'd0);
      reset = 1'b0;

      preload(8'h14, 8'h00);
      preload(8'h20, 8'h01);
      preload(8'h21, 8'h02);
      preload(8'h22, 8'h03);
      preload(8'hFE, 8'h11);
      preload(8'hFF, 8'h22);
      preload(8'h00, 8'h33);
      preload(8'h01, 8'h44);
      preload(8'h90, 8'h00);
      preload(8'h61, 8'h00);

      // 1: fill 0x10 len 4 with 0xA5
      kick(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         chk("fill_wr", {30'd0, MemRead, MemWrite}, 32'd1);
         chk("fill_addr", {24'd0, address}, 32'h10 + i);
         chk("fill_wdata", {24'd0, writeData}, 32'hA5);
         step();
      end
      chk("fill_done", {30'd0, busy, done}, 32'd3);
      chk("fill_done_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      step();
      chk("fill_idle", {30'd0, busy, done}, 32'd0);
      for (int i = 0; i < 4; i++) chk("fill_mem", {24'd0, mem[8'h10 + i]}, 32'hA5);
      chk("fill_mem_after", {24'd0, mem[8'h14]}, 32'h00);

      // 2: copy 0x20..0x22 -> 0x40, pattern R,-,W and done at cycle 10 after the start edge
      kick(1'b0, 8'h20, 8'h40, 8'd3, 8'h00);
      for (int i = 0; i < 3; i++) begin
         chk("copy_r", {30'd0, MemRead, MemWrite}, 32'd2);
         chk("copy_raddr", {24'd0, address}, 32'h20 + i);
         step();
         chk("copy_gap", {30'd0, MemRead, MemWrite}, 32'd0);
         step();
         chk("copy_w", {30'd0, MemRead, MemWrite}, 32'd1);
         chk("copy_waddr", {24'd0, address}, 32'h40 + i);
         chk("copy_wdata", {24'd0, writeData}, 32'd1 + i);
         chk("copy_no_early_done", {31'd0, done}, 32'd0);
         step();
      end
      chk("copy_done", {30'd0, busy, done}, 32'd3);
      step();
      chk("copy_idle", {30'd0, busy, done}, 32'd0);
      for (int i = 0; i < 3; i++) chk("copy_mem", {24'd0, mem[8'h40 + i]}, 32'd1 + i);

      // 3: copy with source address wrap
      kick(1'b0, 8'hFE, 8'h80, 8'd4, 8'h00);
      for (int i = 0; i < 4; i++) begin
         a = 8'hFE + 8'(i);
         chk("wrap_raddr", {24'd0, address}, {24'd0, a});
         step(); step();
         chk("wrap_waddr", {24'd0, address}, 32'h80 + i);
         step();
      end
      chk("wrap_done", {31'd0, done}, 32'd1);
      step();
      chk("wrap_mem80", {24'd0, mem[8'h80]}, 32'h11);
      chk("wrap_mem81", {24'd0, mem[8'h81]}, 32'h22);
      chk("wrap_mem82", {24'd0, mem[8'h82]}, 32'h33);
      chk("wrap_mem83", {24'd0, mem[8'h83]}, 32'h44);

      // 4: zero length
      kick(1'b0, 8'h20, 8'h30, 8'd0, 8'h00);
      chk("zero_done", {30'd0, busy, done}, 32'd3);
      chk("zero_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      step();
      chk("zero_idle", {30'd0, busy, done}, 32'd0);

      // 5: copy 0x40 -> 0x50 len 2 with 3 hold cycles in WRITE and 2 in READ
      kick(1'b0, 8'h40, 8'h50, 8'd2, 8'h00);
      chk("hold_r0", {30'd0, MemRead, MemWrite}, 32'd2);
      step(); step();
      cpuHold = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         chk("hold_w_quiet", {30'd0, MemRead, MemWrite}, 32'd0);
         step();
      end
      cpuHold = 1'b0; #1;
      chk("hold_w0", {30'd0, MemRead, MemWrite}, 32'd1);
      chk("hold_w0_addr", {24'd0, address}, 32'h50);
      step();
      cpuHold = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         chk("hold_r_quiet", {30'd0, MemRead, MemWrite}, 32'd0);
         chk("hold_r_busy", {30'd0, busy, done}, 32'd2);
         step();
      end
      cpuHold = 1'b0; #1;
      chk("hold_r1", {30'd0, MemRead, MemWrite}, 32'd2);
      chk("hold_r1_addr", {24'd0, address}, 32'h41);
      step(); step();
      chk("hold_w1_addr", {24'd0, address}, 32'h51);
      chk("hold_w1_data", {24'd0, writeData}, 32'h02);
      step();
      chk("hold_done", {31'd0, done}, 32'd1);
      step();
      chk("hold_mem50", {24'd0, mem[8'h50]}, 32'h01);
      chk("hold_mem51", {24'd0, mem[8'h51]}, 32'h02);

      // 6: second start while busy is ignored; reset in CAPTURE aborts without done
      kick(1'b0, 8'h20, 8'h60, 8'd8, 8'h00);
      start = 1'b1; mode = 1'b1; dstAddr = 8'h90; length = 8'd2; fillValue = 8'hEE;
      step();
      start = 1'b0;
      step();
      chk("busy_start_wr", {30'd0, MemRead, MemWrite}, 32'd1);
      chk("busy_start_addr", {24'd0, address}, 32'h60);
      chk("busy_start_data", {24'd0, writeData}, 32'h01);
      step();
      chk("busy_start_copy", {30'd0, MemRead, MemWrite}, 32'd2);
      chk("busy_start_raddr", {24'd0, address}, 32'h21);
      step();
      done_before = n_done;
      reset = 1'b1;
      step();
      chk("abort_busy", {30'd0, busy, done}, 32'd0);
      chk("abort_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      reset = 1'b0;
      step(); step();
      chk("abort_no_done", n_done, done_before);
      chk("abort_idle", {31'd0, busy}, 32'd0);
      chk("abort_mem60", {24'd0, mem[8'h60]}, 32'h01);
      chk("abort_mem61", {24'd0, mem[8'h61]}, 32'h00);
      chk("abort_mem90", {24'd0, mem[8'h90]}, 32'h00);

      chk("bus_rules", n_viol, 32'd0);
      chk("done_pulses", n_done, 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
